// File: rtl/bus_controller_hs_if.sv
// Command/bus signal bundle for bus_controller_hs. The master modport is the controller's view.
// The slave modport is the command source and memory side.
interface bus_controller_hs_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              i_Cmd_Valid;
   logic              o_Cmd_Ready;
   logic [1:0]        i_Control_Salida;
   logic [DATA_W-1:0] i_Num8b;
   logic [DATA_W-1:0] i_RX;
   logic [DATA_W-1:0] i_RY;
   logic [DATA_W-1:0] o_Bus_Datos_S;
   logic [ADDR_W-1:0] o_Bus_Direccion_Datos;
   logic              o_Lectura_Escritura;
   logic              o_Bus_Req;
   logic              i_Bus_Ack;
   logic [DATA_W-1:0] i_Bus_Datos_E;
   logic [DATA_W-1:0] o_Dato_Leido;
   logic              o_Done;
   logic              o_Error;

   modport master (
      input  i_Cmd_Valid, i_Control_Salida, i_Num8b, i_RX, i_RY, i_Bus_Ack, i_Bus_Datos_E,
      output o_Cmd_Ready, o_Bus_Datos_S, o_Bus_Direccion_Datos, o_Lectura_Escritura,
             o_Bus_Req, o_Dato_Leido, o_Done, o_Error
   );

   modport slave (
      output i_Cmd_Valid, i_Control_Salida, i_Num8b, i_RX, i_RY, i_Bus_Ack, i_Bus_Datos_E,
      input  o_Cmd_Ready, o_Bus_Datos_S, o_Bus_Direccion_Datos, o_Lectura_Escritura,
             o_Bus_Req, o_Dato_Leido, o_Done, o_Error
   );
endinterface

// File: rtl/bus_controller_hs.sv
// Single-outstanding bus master: turns NOP/LOAD/STORE commands into one req/ack bus cycle.
// A bus cycle ends in a one-cycle o_Done pulse on ack, or an o_Error pulse on timeout.
module bus_controller_hs #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input logic                Clk,
   input logic                Rst,
   bus_controller_hs_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic [1:0] C_NOP       = 2'b00;
   localparam logic [1:0] C_LOAD      = 2'b01;
   localparam logic [1:0] C_STORE_NUM = 2'b10;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rw_q, rw_d;
   logic              req_q, req_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rw_d    = rw_q;
      req_d   = req_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_Cmd_Valid && ready_q) begin
               if (bus.i_Control_Salida == C_NOP) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  cnt_d   = '0;
                  if (bus.i_Control_Salida == C_LOAD) begin
                     addr_d = ADDR_W'(bus.i_RY);
                     data_d = '0;
                     rw_d   = 1'b0;
                  end else begin
                     addr_d = ADDR_W'(bus.i_RX);
                     data_d = (bus.i_Control_Salida == C_STORE_NUM) ? bus.i_Num8b : bus.i_RY;
                     rw_d   = 1'b1;
                  end
               end
            end
         end
         S_REQ: begin
            // Ack is checked before the timeout so a last-cycle ack still completes.
            if (bus.i_Bus_Ack) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               if (!rw_q) rd_d = bus.i_Bus_Datos_E;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = '0;
            data_d  = '0;
            rw_d    = 1'b0;
         end
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         req_q   <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rw_q    <= rw_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_Cmd_Ready           = ready_q;
   assign bus.o_Bus_Direccion_Datos = addr_q;
   assign bus.o_Bus_Datos_S         = data_q;
   assign bus.o_Lectura_Escritura   = rw_q;
   assign bus.o_Bus_Req             = req_q;
   assign bus.o_Dato_Leido          = rd_q;
   assign bus.o_Done                = done_q;
   assign bus.o_Error               = err_q;
endmodule

// File: tb/tb_bus_controller_hs.sv
// Directed bench: a vector table of single commands on an 8/8 instance, then hand sequences
// for busy-time commands, stray ack, async reset mid-cycle, and a 16/12 instance.
module tb_bus_controller_hs;
   localparam int TO = 15;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 Clk = ~Clk;

   bus_controller_hs_if #(.DATA_W(8),  .ADDR_W(8))  ia ();
   bus_controller_hs_if #(.DATA_W(16), .ADDR_W(12)) ib ();

   bus_controller_hs #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(TO)) u_a (
      .Clk(Clk), .Rst(Rst), .bus(ia)
   );
   bus_controller_hs #(.DATA_W(16), .ADDR_W(12), .TIMEOUT(TO)) u_b (
      .Clk(Clk), .Rst(Rst), .bus(ib)
   );

   typedef struct {
      logic [1:0] ctrl;
      logic [7:0] rx, ry, num, rdata;
      int         ack_at;   // 0 = never ack
      logic [7:0] e_addr, e_data;
      logic       e_rw;
      int         e_req;
      logic       e_done, e_err;
      logic [7:0] e_rd;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  w, j, req_cyc;
      bit  fin;
      w = 0;
      while (!ia.o_Cmd_Ready && w < 20) begin
         tick();
         w++;
      end
      chk($sformatf("v%0d ready_before", idx), 32'(ia.o_Cmd_Ready), 32'd1);
      ia.i_Cmd_Valid      = 1'b1;
      ia.i_Control_Salida = v.ctrl;
      ia.i_RX             = v.rx;
      ia.i_RY             = v.ry;
      ia.i_Num8b          = v.num;
      ia.i_Bus_Datos_E    = v.rdata;
      tick();
      ia.i_Cmd_Valid = 1'b0;
      ia.i_RX        = ~v.rx;
      ia.i_RY        = ~v.ry;
      ia.i_Num8b     = ~v.num;
      req_cyc = 0;
      fin     = 1'b0;
      j       = 0;
      while (!fin && j < TO + 3) begin
         if (ia.o_Bus_Req) req_cyc++;
         if (ia.o_Done || ia.o_Error) fin = 1'b1;
         else begin
            j++;
            ia.i_Bus_Ack = (j == v.ack_at);
            tick();
            ia.i_Bus_Ack = 1'b0;
         end
      end
      chk($sformatf("v%0d finished", idx), 32'(fin), 32'd1);
      chk($sformatf("v%0d done", idx), 32'(ia.o_Done), 32'(v.e_done));
      chk($sformatf("v%0d err", idx), 32'(ia.o_Error), 32'(v.e_err));
      chk($sformatf("v%0d req_cycles", idx), 32'(req_cyc), 32'(v.e_req));
      chk($sformatf("v%0d req_low", idx), 32'(ia.o_Bus_Req), 32'd0);
      chk($sformatf("v%0d addr", idx), 32'(ia.o_Bus_Direccion_Datos), 32'(v.e_addr));
      chk($sformatf("v%0d data", idx), 32'(ia.o_Bus_Datos_S), 32'(v.e_data));
      chk($sformatf("v%0d rw", idx), 32'(ia.o_Lectura_Escritura), 32'(v.e_rw));
      chk($sformatf("v%0d rd", idx), 32'(ia.o_Dato_Leido), 32'(v.e_rd));
      chk($sformatf("v%0d ready_in_end", idx), 32'(ia.o_Cmd_Ready), 32'd0);
      tick();
      chk($sformatf("v%0d ready_after", idx), 32'(ia.o_Cmd_Ready), 32'd1);
      chk($sformatf("v%0d pulse_gone", idx), 32'({ia.o_Done, ia.o_Error}), 32'd0);
      chk($sformatf("v%0d idle_zero", idx),
          32'({ia.o_Bus_Direccion_Datos, ia.o_Bus_Datos_S, ia.o_Lectura_Escritura}), 32'd0);
   endtask

   initial begin
      //        ctrl   rx     ry     num    rdata  ack  addr   data   rw   req done err rd
      vt[0] = '{2'b10, 8'h20, 8'h00, 8'h5A, 8'h00, 2,  8'h20, 8'h5A, 1'b1, 2,  1'b1, 1'b0, 8'h00};
      vt[1] = '{2'b01, 8'h00, 8'h31, 8'h00, 8'hC3, 1,  8'h31, 8'h00, 1'b0, 1,  1'b1, 1'b0, 8'hC3};
      vt[2] = '{2'b11, 8'h44, 8'h99, 8'h00, 8'h00, 0,  8'h44, 8'h99, 1'b1, 15, 1'b0, 1'b1, 8'hC3};
      vt[3] = '{2'b01, 8'h00, 8'h7E, 8'h00, 8'h5F, 15, 8'h7E, 8'h00, 1'b0, 15, 1'b1, 1'b0, 8'h5F};
      vt[4] = '{2'b00, 8'h12, 8'h34, 8'h56, 8'h00, 0,  8'h00, 8'h00, 1'b0, 0,  1'b1, 1'b0, 8'h5F};
      vt[5] = '{2'b01, 8'h00, 8'h0F, 8'h00, 8'hAA, 0,  8'h0F, 8'h00, 1'b0, 15, 1'b0, 1'b1, 8'h5F};
      vt[6] = '{2'b11, 8'h01, 8'hFE, 8'h00, 8'h00, 3,  8'h01, 8'hFE, 1'b1, 3,  1'b1, 1'b0, 8'h5F};

      ia.i_Cmd_Valid = 0; ia.i_Control_Salida = 0; ia.i_Num8b = 0; ia.i_RX = 0; ia.i_RY = 0;
      ia.i_Bus_Ack = 0; ia.i_Bus_Datos_E = 0;
      ib.i_Cmd_Valid = 0; ib.i_Control_Salida = 0; ib.i_Num8b = 0; ib.i_RX = 0; ib.i_RY = 0;
      ib.i_Bus_Ack = 0; ib.i_Bus_Datos_E = 0;

      // Reset state, and ready only on the first edge after release
      #1 Rst = 1'b0;
      #2;
      chk("rst ready", 32'(ia.o_Cmd_Ready), 32'd0);
      chk("rst outs", 32'({ia.o_Bus_Req, ia.o_Done, ia.o_Error, ia.o_Lectura_Escritura}), 32'd0);
      chk("rst rd", 32'(ia.o_Dato_Leido), 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk("rel ready_pre", 32'(ia.o_Cmd_Ready), 32'd0);
      tick();
      chk("rel ready_edge", 32'(ia.o_Cmd_Ready), 32'd1);

      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

      // Stray ack in IDLE has no effect
      ia.i_Bus_Ack = 1'b1; ia.i_Bus_Datos_E = 8'hEE;
      tick();
      ia.i_Bus_Ack = 1'b0;
      chk("stray pulses", 32'({ia.o_Done, ia.o_Error, ia.o_Bus_Req}), 32'd0);
      chk("stray rd", 32'(ia.o_Dato_Leido), 32'h5F);
      chk("stray ready", 32'(ia.o_Cmd_Ready), 32'd1);

      // Command held valid while busy is taken only after the return to IDLE
      ia.i_Cmd_Valid = 1'b1; ia.i_Control_Salida = 2'b10; ia.i_RX = 8'h10; ia.i_Num8b = 8'h11;
      tick();
      chk("busy acc1 req", 32'(ia.o_Bus_Req), 32'd1);
      ia.i_Control_Salida = 2'b01; ia.i_RY = 8'h22; ia.i_Bus_Datos_E = 8'h66;
      ia.i_Bus_Ack = 1'b1;
      tick();
      ia.i_Bus_Ack = 1'b0;
      chk("busy done1", 32'(ia.o_Done), 32'd1);
      chk("busy addr1", 32'(ia.o_Bus_Direccion_Datos), 32'h10);
      chk("busy rd1", 32'(ia.o_Dato_Leido), 32'h5F);
      tick();
      chk("busy idle ready", 32'(ia.o_Cmd_Ready), 32'd1);
      chk("busy idle req", 32'(ia.o_Bus_Req), 32'd0);
      tick();
      ia.i_Cmd_Valid = 1'b0;
      chk("busy acc2 req", 32'(ia.o_Bus_Req), 32'd1);
      chk("busy acc2 addr", 32'(ia.o_Bus_Direccion_Datos), 32'h22);
      chk("busy acc2 rw", 32'(ia.o_Lectura_Escritura), 32'd0);
      ia.i_Bus_Ack = 1'b1;
      tick();
      ia.i_Bus_Ack = 1'b0;
      chk("busy done2", 32'(ia.o_Done), 32'd1);
      chk("busy rd2", 32'(ia.o_Dato_Leido), 32'h66);
      tick();

      // Async reset in the middle of a bus cycle
      ia.i_Cmd_Valid = 1'b1; ia.i_Control_Salida = 2'b10; ia.i_RX = 8'h40; ia.i_Num8b = 8'h41;
      tick();
      ia.i_Cmd_Valid = 1'b0;
      tick();
      chk("arst pre req", 32'(ia.o_Bus_Req), 32'd1);
      #2 Rst = 1'b0;
      #1;
      chk("arst req", 32'(ia.o_Bus_Req), 32'd0);
      chk("arst bus", 32'({ia.o_Bus_Direccion_Datos, ia.o_Bus_Datos_S, ia.o_Lectura_Escritura}), 32'd0);
      chk("arst ready", 32'(ia.o_Cmd_Ready), 32'd0);
      chk("arst rd", 32'(ia.o_Dato_Leido), 32'd0);
      ia.i_Bus_Ack = 1'b1;
      tick();
      tick();
      ia.i_Bus_Ack = 1'b0;
      chk("arst no pulse", 32'({ia.o_Done, ia.o_Error, ia.o_Bus_Req}), 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      tick();
      chk("arst ready after", 32'(ia.o_Cmd_Ready), 32'd1);
      chk("arst cmd gone", 32'({ia.o_Done, ia.o_Error, ia.o_Bus_Req}), 32'd0);

      // Wide instance: address keeps the low 12 bits of RX
      ib.i_Cmd_Valid = 1'b1; ib.i_Control_Salida = 2'b10; ib.i_RX = 16'hABCD; ib.i_Num8b = 16'h1234;
      tick();
      ib.i_Cmd_Valid = 1'b0; ib.i_RX = 16'h0000;
      chk("w16 req", 32'(ib.o_Bus_Req), 32'd1);
      chk("w16 addr", 32'(ib.o_Bus_Direccion_Datos), 32'hBCD);
      chk("w16 data", 32'(ib.o_Bus_Datos_S), 32'h1234);
      chk("w16 rw", 32'(ib.o_Lectura_Escritura), 32'd1);
      tick();
      chk("w16 req2", 32'(ib.o_Bus_Req), 32'd1);
      ib.i_Bus_Ack = 1'b1;
      tick();
      ib.i_Bus_Ack = 1'b0;
      chk("w16 done", 32'({ib.o_Done, ib.o_Error, ib.o_Bus_Req}), 32'b100);
      chk("w16 addr hold", 32'(ib.o_Bus_Direccion_Datos), 32'hBCD);
      tick();
      chk("w16 ready", 32'(ib.o_Cmd_Ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bus_controller_hs.md
BUS_CONTROLLER_HS -- requirements
Module: bus_controller_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bus and register operand width.
REQ-002 SHALL have parameter ADDR_W, default 8, address bus width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles to wait for i_Bus_Ack; legal range >= 1.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_Cmd_Valid  input  1  command present.
REQ-007 SHALL have port o_Cmd_Ready  output  1  block can accept a command.
REQ-008 SHALL have port i_Control_Salida  input  2  00 NOP, 01 LOAD_Registros, 10 STORE_Num, 11 STORE_Registro.
REQ-009 SHALL have port i_Num8b  input  DATA_W  immediate operand.
REQ-010 SHALL have ports i_RX, i_RY  input  DATA_W  register operands.
REQ-011 SHALL have port o_Bus_Datos_S  output  DATA_W  write data.
REQ-012 SHALL have port o_Bus_Direccion_Datos  output  ADDR_W  address.
REQ-013 SHALL have port o_Lectura_Escritura  output  1  0 read, 1 write.
REQ-014 SHALL have port o_Bus_Req  output  1  bus cycle request.
REQ-015 SHALL have ports i_Bus_Ack  input  1, and i_Bus_Datos_E  input  DATA_W: memory acknowledge and read data.
REQ-016 SHALL have ports o_Dato_Leido  output  DATA_W (last read data), o_Done  output  1, and o_Error  output  1 (one-cycle pulses).

Function
REQ-017 SHALL implement states IDLE, REQ, DONE, ERR; all outputs registered.
REQ-018 SHALL assert o_Cmd_Ready only in IDLE; a command is accepted on an edge with i_Cmd_Valid=1 and o_Cmd_Ready=1; commands presented while busy are ignored.
REQ-019 SHALL, on accepting NOP, go to DONE without asserting o_Bus_Req.
REQ-020 SHALL, on accepting LOAD at edge k, drive address=i_RY, o_Lectura_Escritura=0, o_Bus_Datos_S=0, o_Bus_Req=1 from edge k (state REQ).
REQ-021 SHALL, on STORE_Num, drive address=i_RX, data=i_Num8b, o_Lectura_Escritura=1; on STORE_Registro, address=i_RX, data=i_RY, o_Lectura_Escritura=1; otherwise as REQ-020.
REQ-022 SHALL form address from the low ADDR_W bits of the operand, zero-extended when ADDR_W > DATA_W.
REQ-023 SHALL hold address, data, direction, and o_Bus_Req stable throughout REQ, regardless of operand input changes.
REQ-024 SHALL, in REQ, accept i_Bus_Ack=1 sampled at edges k+1..k+TIMEOUT: enter DONE, drop o_Bus_Req, pulse o_Done; a LOAD captures i_Bus_Datos_E into o_Dato_Leido at that edge.
REQ-025 SHALL, if no ack is sampled by edge k+TIMEOUT, enter ERR at that edge: drop o_Bus_Req, pulse o_Error, leave o_Dato_Leido unchanged.
REQ-026 SHALL give ack priority when ack and timeout coincide at edge k+TIMEOUT.
REQ-027 SHALL leave DONE/ERR for IDLE after exactly one cycle, zeroing address, data, and direction; a command takes n+2 cycles for ack at edge k+n.
REQ-028 SHALL ignore i_Bus_Ack outside REQ.
REQ-029 SHALL size the timeout counter as clog2(TIMEOUT+1) bits, cleared on REQ entry, with no wrap.

Reset
REQ-030 SHALL, while Rst=0, immediately force state IDLE and all outputs, including o_Dato_Leido, o_Cmd_Ready, and the counter, to 0.
REQ-031 SHALL assert o_Cmd_Ready on the first rising edge after Rst rises.
REQ-032 SHALL, on reset during REQ, drop o_Bus_Req asynchronously, pulse neither o_Done nor o_Error, and discard the command.

Verification
REQ-033 SHALL cover: STORE_Num with RX=0x20, Num=0x5A, ack after 2 cycles -> address 0x20, data 0x5A, RW=1, Req high 2 cycles, o_Done pulse, Ready back 1 cycle later.
REQ-034 SHALL cover: LOAD with RY=0x31, i_Bus_Datos_E=0xC3, ack after 1 cycle -> RW=0, o_Dato_Leido=0xC3, o_Done pulse.
REQ-035 SHALL cover: STORE_Registro, ack never, TIMEOUT=15 -> Req high exactly 15 cycles, o_Error pulse, o_Dato_Leido unchanged.
REQ-036 SHALL cover: ack exactly at edge k+TIMEOUT -> o_Done, not o_Error.
REQ-037 SHALL cover: second command held valid during REQ, plus stray ack in IDLE -> second command accepted only after return to IDLE; stray ack causes no effect.
REQ-038 SHALL cover: Rst low mid-REQ -> all outputs 0 without waiting for Clk; Ready=1 one edge after release; DATA_W=16, ADDR_W=12 rerun of the first scenario -> address is the low 12 bits.
